// File: rtl/mux_pipe_reg_pkg.sv
// Shared constants and types for the registered N-way word select.
package mux_pipe_reg_pkg;

  localparam int DATAPATH_WIDTH = 16;

  // Encoding bit 0 = main holds a beat, bit 1 = skid holds a beat.
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'b00,
    SKID_ONE   = 2'b01,
    SKID_FULL  = 2'b11
  } skid_state_e;

endpackage

// File: rtl/mux_skid_buf.sv
// Two-entry valid/ready pipeline stage: a main output register plus one skid
// entry, so that in_ready comes straight from a flop.
module mux_skid_buf
  import mux_pipe_reg_pkg::*;
#(
  parameter int PW = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [PW-1:0] in_payload,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [PW-1:0] out_payload,
  output logic          out_valid,
  input  logic          out_ready
);

  skid_state_e   r_state;
  logic [PW-1:0] r_main;
  logic [PW-1:0] r_skid;
  logic          r_out_valid;
  logic          r_in_ready;
  logic          w_accept;
  logic          w_drain;

  assign w_accept    = in_valid & r_in_ready;
  assign w_drain     = r_out_valid & out_ready;
  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out_payload = r_main;

  // Occupancy FSM; in_ready is precomputed as the next-cycle "skid empty".
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= SKID_EMPTY;
      r_main      <= '0;
      r_skid      <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        SKID_EMPTY: begin
          if (w_accept) begin
            r_main      <= in_payload;
            r_out_valid <= 1'b1;
            r_state     <= SKID_ONE;
          end
        end
        SKID_ONE: begin
          if (w_accept && w_drain) begin
            r_main <= in_payload;
          end else if (w_accept) begin
            r_skid     <= in_payload;
            r_in_ready <= 1'b0;
            r_state    <= SKID_FULL;
          end else if (w_drain) begin
            r_out_valid <= 1'b0;
            r_state     <= SKID_EMPTY;
          end
        end
        SKID_FULL: begin
          if (w_drain) begin
            r_main     <= r_skid;
            r_skid     <= '0;
            r_in_ready <= 1'b1;
            r_state    <= SKID_ONE;
          end
        end
        default: begin
          r_state     <= SKID_EMPTY;
          r_skid      <= '0;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/mux_pipe_reg.sv
// N-way word select with range check, captured into a back-pressurable
// skid stage; out-of-range beats carry a zero word and a sticky error flag.
module mux_pipe_reg
  import mux_pipe_reg_pkg::*;
#(
  parameter int WIDTH  = DATAPATH_WIDTH,
  parameter int NUM_IN = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_IN*WIDTH-1:0]   in_data,
  input  logic [$clog2(NUM_IN)-1:0] in_sel,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [$clog2(NUM_IN)-1:0] out_sel,
  output logic                      out_err,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      err_sticky
);

  localparam int SEL_W = $clog2(NUM_IN);
  localparam int PW    = WIDTH + SEL_W + 1;
  localparam logic [SEL_W:0] NUM_IN_CODE = NUM_IN[SEL_W:0];

  logic [WIDTH-1:0] w_word;
  logic             w_err;
  logic             w_in_ready;
  logic [PW-1:0]    w_in_payload;
  logic [PW-1:0]    w_out_payload;
  logic             r_err_sticky;

  // AND-OR select: a code with no matching input leaves the word at zero.
  always_comb begin
    w_word = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      w_word = w_word | (in_data[k*WIDTH +: WIDTH] & {WIDTH{in_sel == k[SEL_W-1:0]}});
    end
  end

  assign w_err        = ({1'b0, in_sel} >= NUM_IN_CODE);
  assign w_in_payload = {w_err, in_sel, w_word};

  mux_skid_buf #(
    .PW (PW)
  ) u_skid (
    .clock       (clock),
    .reset       (reset),
    .in_payload  (w_in_payload),
    .in_valid    (in_valid),
    .in_ready    (w_in_ready),
    .out_payload (w_out_payload),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  // Sticky error: set on any accepted out-of-range beat, cleared only by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_err_sticky <= 1'b0;
    end else if (in_valid && w_in_ready && w_err) begin
      r_err_sticky <= 1'b1;
    end else begin
      r_err_sticky <= r_err_sticky;
    end
  end

  assign in_ready                     = w_in_ready;
  assign {out_err, out_sel, out_data} = w_out_payload;
  assign err_sticky                   = r_err_sticky;

endmodule

// File: tb/tb_mux_pipe_reg.sv
// Scoreboard bench: drivers queue hand-computed expected beats on accept,
// a monitor thread pops and compares whenever an output beat is taken.
module tb_mux_pipe_reg;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  s;
    logic        e;
  } beat_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int    n_cmp = 0;
  int    n_err = 0;
  beat_t q    [4][$];
  beat_t pend [4];

  // A: 16-bit x4, B: 16-bit x3, C: 8-bit x2, D: 32-bit x8
  logic [63:0]  a_in_data;  logic [1:0] a_in_sel;  logic a_in_valid, a_in_ready;
  logic [15:0]  a_out_data; logic [1:0] a_out_sel; logic a_out_err, a_out_valid, a_out_ready, a_sticky;
  logic [47:0]  b_in_data;  logic [1:0] b_in_sel;  logic b_in_valid, b_in_ready;
  logic [15:0]  b_out_data; logic [1:0] b_out_sel; logic b_out_err, b_out_valid, b_out_ready, b_sticky;
  logic [15:0]  c_in_data;  logic [0:0] c_in_sel;  logic c_in_valid, c_in_ready;
  logic [7:0]   c_out_data; logic [0:0] c_out_sel; logic c_out_err, c_out_valid, c_out_ready, c_sticky;
  logic [255:0] d_in_data;  logic [2:0] d_in_sel;  logic d_in_valid, d_in_ready;
  logic [31:0]  d_out_data; logic [2:0] d_out_sel; logic d_out_err, d_out_valid, d_out_ready, d_sticky;

  mux_pipe_reg #(.WIDTH(16), .NUM_IN(4)) dut_a (
    .clock(clock), .reset(reset), .in_data(a_in_data), .in_sel(a_in_sel),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .out_data(a_out_data),
    .out_sel(a_out_sel), .out_err(a_out_err), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .err_sticky(a_sticky));

  mux_pipe_reg #(.WIDTH(16), .NUM_IN(3)) dut_b (
    .clock(clock), .reset(reset), .in_data(b_in_data), .in_sel(b_in_sel),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .out_data(b_out_data),
    .out_sel(b_out_sel), .out_err(b_out_err), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .err_sticky(b_sticky));

  mux_pipe_reg #(.WIDTH(8), .NUM_IN(2)) dut_c (
    .clock(clock), .reset(reset), .in_data(c_in_data), .in_sel(c_in_sel),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .out_data(c_out_data),
    .out_sel(c_out_sel), .out_err(c_out_err), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .err_sticky(c_sticky));

  mux_pipe_reg #(.WIDTH(32), .NUM_IN(8)) dut_d (
    .clock(clock), .reset(reset), .in_data(d_in_data), .in_sel(d_in_sel),
    .in_valid(d_in_valid), .in_ready(d_in_ready), .out_data(d_out_data),
    .out_sel(d_out_sel), .out_err(d_out_err), .out_valid(d_out_valid),
    .out_ready(d_out_ready), .err_sticky(d_sticky));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic pop_chk(input int id, input string nm, input logic [31:0] d,
                         input logic [3:0] s, input logic e);
    beat_t b;
    if (q[id].size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_unexpected_beat: got data 0x%0h, expected no beat (t=%0t)", nm, d, $time);
    end else begin
      b = q[id].pop_front();
      chk({nm, "_data"}, d, b.d);
      chk({nm, "_sel"}, {28'h0, s}, {28'h0, b.s});
      chk({nm, "_err"}, {31'h0, e}, {31'h0, b.e});
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic a_drive(input logic [1:0] sel, input logic [15:0] exp);
    a_in_sel   = sel;
    a_in_valid = 1'b1;
    pend[0].d  = {16'h0, exp};
    pend[0].s  = {2'b00, sel};
    pend[0].e  = 1'b0;
  endtask

  task automatic b_drive(input logic [1:0] sel, input logic [15:0] exp, input logic err);
    b_in_sel   = sel;
    b_in_valid = 1'b1;
    pend[1].d  = {16'h0, exp};
    pend[1].s  = {2'b00, sel};
    pend[1].e  = err;
  endtask

  logic [15:0] stream_exp [4];
  logic [7:0]  cw [2];
  logic [31:0] dw [8];
  int          csel, dsel;

  initial begin
    stream_exp = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    a_in_data = 64'h0; a_in_sel = 2'd0; a_in_valid = 1'b0; a_out_ready = 1'b0;
    b_in_data = 48'h0; b_in_sel = 2'd0; b_in_valid = 1'b0; b_out_ready = 1'b0;
    c_in_data = 16'h0; c_in_sel = 1'b0; c_in_valid = 1'b0; c_out_ready = 1'b0;
    d_in_data = 256'h0; d_in_sel = 3'd0; d_in_valid = 1'b0; d_out_ready = 1'b0;

    fork
      forever begin
        @(negedge clock);
        if (!reset) begin
          if (a_out_valid && a_out_ready) pop_chk(0, "A", {16'h0, a_out_data}, {2'b00, a_out_sel}, a_out_err);
          if (b_out_valid && b_out_ready) pop_chk(1, "B", {16'h0, b_out_data}, {2'b00, b_out_sel}, b_out_err);
          if (c_out_valid && c_out_ready) pop_chk(2, "C", {24'h0, c_out_data}, {3'b000, c_out_sel}, c_out_err);
          if (d_out_valid && d_out_ready) pop_chk(3, "D", d_out_data, {1'b0, d_out_sel}, d_out_err);
          if (a_in_valid && a_in_ready) q[0].push_back(pend[0]);
          if (b_in_valid && b_in_ready) q[1].push_back(pend[1]);
          if (c_in_valid && c_in_ready) q[2].push_back(pend[2]);
          if (d_in_valid && d_in_ready) q[3].push_back(pend[3]);
        end
      end
    join_none

    // Reset state
    repeat (3) tick;
    chk("rst_out_valid", {31'h0, a_out_valid}, 32'h0);
    chk("rst_out_data", {16'h0, a_out_data}, 32'h0);
    chk("rst_out_sel", {30'h0, a_out_sel}, 32'h0);
    chk("rst_out_err", {31'h0, a_out_err}, 32'h0);
    chk("rst_sticky", {31'h0, a_sticky}, 32'h0);
    chk("rst_in_ready", {31'h0, a_in_ready}, 32'h1);
    reset = 1'b0;
    tick;
    chk("rel_out_valid", {31'h0, a_out_valid}, 32'h0);

    // Single beat, one-cycle latency
    a_in_data   = 64'h4444_3333_2222_1111;
    a_out_ready = 1'b1;
    a_drive(2'd2, 16'h3333);
    tick;
    a_in_valid = 1'b0;
    chk("lat_valid", {31'h0, a_out_valid}, 32'h1);
    chk("lat_data", {16'h0, a_out_data}, 32'h3333);
    chk("lat_sel", {30'h0, a_out_sel}, 32'h2);
    chk("lat_err", {31'h0, a_out_err}, 32'h0);
    tick;

    // Streaming at one beat per cycle
    for (int i = 0; i < 4; i++) begin
      a_drive(i[1:0], stream_exp[i]);
      chk("stream_in_ready", {31'h0, a_in_ready}, 32'h1);
      tick;
      chk("stream_data", {16'h0, a_out_data}, {16'h0, stream_exp[i]});
    end
    a_in_valid = 1'b0;
    tick;
    chk("stream_empty", {31'h0, a_out_valid}, 32'h0);

    // Back-pressure: two accepted, third stalls until the skid drains
    a_out_ready = 1'b0;
    a_drive(2'd0, 16'h1111); tick;
    a_drive(2'd1, 16'h2222); tick;
    a_drive(2'd2, 16'h3333);
    a_in_data = 64'hDEAD_BEEF_0BAD_F00D;
    repeat (3) begin
      chk("bp_in_ready", {31'h0, a_in_ready}, 32'h0);
      chk("bp_hold_data", {16'h0, a_out_data}, 32'h1111);
      tick;
    end
    a_in_data   = 64'h4444_3333_2222_1111;
    a_out_ready = 1'b1;
    tick;
    chk("bp_drain1", {16'h0, a_out_data}, 32'h2222);
    chk("bp_ready_back", {31'h0, a_in_ready}, 32'h1);
    tick;
    chk("bp_drain2", {16'h0, a_out_data}, 32'h3333);
    a_in_valid = 1'b0;
    tick;
    chk("bp_empty", {31'h0, a_out_valid}, 32'h0);

    // Out-of-range select with NUM_IN=3
    b_in_data   = 48'h3333_2222_1111;
    b_out_ready = 1'b1;
    b_drive(2'd1, 16'h2222, 1'b0); tick;
    b_in_valid = 1'b0;
    chk("oor_sticky_pre", {31'h0, b_sticky}, 32'h0);
    tick;
    b_drive(2'd3, 16'h0000, 1'b1);
    chk("oor_sticky_before", {31'h0, b_sticky}, 32'h0);
    tick;
    b_in_valid = 1'b0;
    chk("oor_data", {16'h0, b_out_data}, 32'h0);
    chk("oor_err", {31'h0, b_out_err}, 32'h1);
    chk("oor_sticky", {31'h0, b_sticky}, 32'h1);
    b_drive(2'd0, 16'h1111, 1'b0); tick;
    b_drive(2'd2, 16'h3333, 1'b0); tick;
    b_in_valid = 1'b0;
    repeat (2) tick;
    chk("oor_sticky_hold", {31'h0, b_sticky}, 32'h1);

    // Reset while FULL discards both held beats
    a_out_ready = 1'b0;
    a_drive(2'd3, 16'h4444); tick;
    a_drive(2'd0, 16'h1111); tick;
    a_in_valid = 1'b0;
    chk("full_in_ready", {31'h0, a_in_ready}, 32'h0);
    chk("full_out_valid", {31'h0, a_out_valid}, 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("async_out_valid", {31'h0, a_out_valid}, 32'h0);
    chk("async_in_ready", {31'h0, a_in_ready}, 32'h1);
    chk("async_out_data", {16'h0, a_out_data}, 32'h0);
    q[0].delete();
    a_out_ready = 1'b1;
    repeat (2) tick;
    chk("rst_clears_sticky", {31'h0, b_sticky}, 32'h0);
    reset = 1'b0;
    repeat (4) begin
      tick;
      chk("no_stale_beat", {31'h0, a_out_valid}, 32'h0);
    end
    a_drive(2'd1, 16'h2222); tick;
    a_in_valid = 1'b0;
    chk("post_rst_beat", {16'h0, a_out_data}, 32'h2222);
    tick;

    // Parameter sweep with random back-pressure
    for (int n = 0; n < 120; n++) begin
      for (int k = 0; k < 2; k++) begin
        cw[k] = 8'($urandom_range(0, 255));
        c_in_data[k*8 +: 8] = cw[k];
      end
      csel       = int'($urandom_range(0, 1));
      c_in_sel   = csel[0:0];
      c_in_valid = ($urandom_range(0, 9) < 7);
      c_out_ready = ($urandom_range(0, 9) < 6);
      pend[2].d  = {24'h0, cw[csel]};
      pend[2].s  = {3'b000, c_in_sel};
      pend[2].e  = 1'b0;
      for (int k = 0; k < 8; k++) begin
        dw[k] = $urandom;
        d_in_data[k*32 +: 32] = dw[k];
      end
      dsel       = int'($urandom_range(0, 7));
      d_in_sel   = dsel[2:0];
      d_in_valid = ($urandom_range(0, 9) < 7);
      d_out_ready = ($urandom_range(0, 9) < 6);
      pend[3].d  = dw[dsel];
      pend[3].s  = {1'b0, d_in_sel};
      pend[3].e  = 1'b0;
      tick;
    end
    c_in_valid = 1'b0; c_out_ready = 1'b1;
    d_in_valid = 1'b0; d_out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (q[0].size() + q[1].size() + q[2].size() + q[3].size() == 0) break;
      tick;
    end
    tick;
    chk("drain_a", q[0].size(), 32'h0);
    chk("drain_b", q[1].size(), 32'h0);
    chk("drain_c", q[2].size(), 32'h0);
    chk("drain_d", q[3].size(), 32'h0);
    chk("sweep_c_sticky", {31'h0, c_sticky}, 32'h0);
    chk("sweep_d_sticky", {31'h0, d_sticky}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mux_pipe_reg.md
# mux_pipe_reg

Parametrised N-way word select with a registered, back-pressurable output stage, replacing the purely combinational 4-input 16-bit select on datapath paths that must cross a pipeline boundary. Captures the selected input word together with its select code on a valid/ready handshake, presents it one cycle later, and absorbs a single stalled beat in a skid register so the upstream ready signal is fully registered. Out-of-range select codes are flagged rather than silently aliased.

## Interface
- WIDTH, 16, data word width in bits (machine word).
- NUM_IN, 4, number of input words; ≥2.
- SEL_W (localparam), $clog2(NUM_IN), select code width; not overridable.

- clock  in  1  rising-edge clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- in_data  in  NUM_IN*WIDTH  flattened inputs; word k occupies bits [k*WIDTH +: WIDTH].
- in_sel  in  SEL_W  select code for this beat.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  block can accept; equals NOT skid_valid; driven only from flops.
- out_data  out  WIDTH  selected word.
- out_sel  out  SEL_W  select code captured with the word.
- out_err  out  1  beat was captured with in_sel ≥ NUM_IN.
- out_valid  out  1  output beat present.
- out_ready  in  1  downstream accepts.
- err_sticky  out  1  set by any accepted out-of-range beat; cleared only by reset.

## Operation
- Accept = in_valid & in_ready. Drain = out_valid & out_ready.
- Selected word = in_data[in_sel*WIDTH +: WIDTH] when in_sel < NUM_IN, else all zeros with err bit 1.
- Two stages: main register (drives out_*) and skid register.
- States (skid_valid, main_valid): EMPTY (0,0), ONE (0,1), FULL (1,1).
  - EMPTY: accept -> load main -> ONE.
  - ONE: accept & drain -> reload main, stay ONE; accept & !drain -> load skid -> FULL; drain & !accept -> EMPTY.
  - FULL: in_ready=0, no accept; drain -> main <= skid, skid cleared -> ONE; else hold.
- Beats leave in acceptance order; no beat dropped or duplicated.
- While out_valid & !out_ready, out_data/out_sel/out_err are stable.
- Invalid in_valid/in_sel/in_data ignored when not accepted; in_data changing under a stall has no effect.
- When NUM_IN is a power of two, out-of-range is unreachable; out_err stays 0.

## Timing
- Reset (async assert, sync-released by system): out_valid=0, out_data=0, out_sel=0, out_err=0, err_sticky=0, skid cleared, in_ready=1.
- Reset mid-operation: all held beats discarded immediately; no output beat after release until a new accept.
- Latency: accept in cycle t -> out_valid with that beat in cycle t+1.
- Throughput: one beat per cycle while out_ready held high.
- First stall: beat accepted in cycle t with main full and !out_ready goes to skid; in_ready low from t+1 until the cycle after skid drains.
- err_sticky rises the cycle after the offending accept.

## Structure
- WIDTH default (machine word width) comes from the shared datapath constants file; no new shared typedefs.
- One sub-module natural: mux_skid_buf (WIDTH+SEL_W+1-bit payload two-entry skid stage with valid/ready); top does selection, range check, and sticky flag.

## Test plan
- Reset then single beat: in_data words {0x1111,0x2222,0x3333,0x4444}, in_sel=2, out_ready=1 -> next cycle out_valid=1, out_data=0x3333, out_sel=2, out_err=0.
- Streaming: in_sel 0,1,2,3 on consecutive cycles, out_ready=1 -> out_data 0x1111,0x2222,0x3333,0x4444 on consecutive cycles, in_ready never low.
- Back-pressure: out_ready=0, offer sel 0 then 1 then 2 -> two accepted, in_ready=0 from third cycle, out_data held 0x1111; raise out_ready -> 0x1111, 0x2222, then 0x3333 accepted and emitted in order.
- Out-of-range with NUM_IN=3: in_sel=3 -> out_data=0, out_err=1, err_sticky=1 and stays 1 after later valid beats until reset.
- Reset while FULL: assert reset with two beats held -> out_valid=0, in_ready=1 immediately; after release no stale beat appears.
- Parameter sweep WIDTH=8/32, NUM_IN=2/8: random beats with random out_ready against a scoreboard -> order and data match, no loss.
